// File: rtl/dice_pkg.sv
// Shared types and constants for the dice roll controller: FSM states, face
// range and the 7-LED pip patterns.
package dice_pkg;

    localparam int unsigned FACE_W = 3;
    localparam int unsigned PIPS_W = 7;

    localparam logic [FACE_W-1:0] FACE_MIN = 3'd1;
    localparam logic [FACE_W-1:0] FACE_MAX = 3'd6;

    // bit0 TL, bit1 TR, bit2 ML, bit3 C, bit4 MR, bit5 BL, bit6 BR
    localparam logic [PIPS_W-1:0] PIPS_OFF = 7'b0000000;
    localparam logic [PIPS_W-1:0] PIPS_1   = 7'b0001000;
    localparam logic [PIPS_W-1:0] PIPS_2   = 7'b1000001;
    localparam logic [PIPS_W-1:0] PIPS_3   = 7'b1001001;
    localparam logic [PIPS_W-1:0] PIPS_4   = 7'b1100011;
    localparam logic [PIPS_W-1:0] PIPS_5   = 7'b1101011;
    localparam logic [PIPS_W-1:0] PIPS_6   = 7'b1110111;

    typedef enum logic [1:0] {
        IDLE,
        ROLLING,
        SETTLING,
        SHOW
    } state_e;

    function automatic logic face_valid(input logic [FACE_W-1:0] f);
        return (f >= FACE_MIN) && (f <= FACE_MAX);
    endfunction

    function automatic logic [PIPS_W-1:0] face_to_pips(input logic [FACE_W-1:0] f);
        case (f)
            3'd1:    return PIPS_1;
            3'd2:    return PIPS_2;
            3'd3:    return PIPS_3;
            3'd4:    return PIPS_4;
            3'd5:    return PIPS_5;
            3'd6:    return PIPS_6;
            default: return PIPS_OFF;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and
// single-cycle press/release strobes of the debounced level.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press_c,
    output logic release_c
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flip_c;

    // Level flips in the cycle the count would reach DEBOUNCE_CYCLES
    always_comb begin
        flip_c  = (sync2_q != level_q) && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
        cnt_d   = '0;
        level_d = level_q;
        if (flip_c) begin
            level_d = sync2_q;
        end else if (sync2_q != level_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign press_c   = flip_c & sync2_q;
    assign release_c = flip_c & ~sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/dice_roll_ctrl.sv
// Dice roll controller: animates the die while the button is held, latches one
// face on release. Define DICE_SETTLE_ANIM_EN to build the decelerating SETTLING phase.
module dice_roll_ctrl
    import dice_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned ANIM_BASE       = 4,
    parameter int unsigned SETTLE_STEPS    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FACE_W-1:0] dice_value,
    input  logic              btn,
    output logic [PIPS_W-1:0] pips,
    output logic [FACE_W-1:0] result,
    output logic              result_valid,
    output logic              is_three,
    output logic              busy
);
    localparam int unsigned       TICK_W    = $clog2(ANIM_BASE * (SETTLE_STEPS + 1) + 1);
    localparam logic [TICK_W-1:0] TICK_WRAP = TICK_W'(ANIM_BASE - 1);

    state_e              state_q, state_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [FACE_W-1:0]   disp_q, disp_d;
    logic [FACE_W-1:0]   result_q, result_d;
    logic [PIPS_W-1:0]   pips_q, pips_d;
    logic                result_valid_q, result_valid_d;
    logic                is_three_q, is_three_d;
    logic                busy_q, busy_d;
    logic                press_c, release_c, sample_c;
`ifdef DICE_SETTLE_ANIM_EN
    localparam int unsigned STEP_W = $clog2(SETTLE_STEPS + 1);
    logic [STEP_W-1:0]   step_q, step_d;
    logic [TICK_W-1:0]   interval_c;
`else
    logic                pend_q, pend_d;
`endif

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .press_c   (press_c),
        .release_c (release_c)
    );

    always_comb begin
        state_d        = state_q;
        tick_d         = tick_q;
        disp_d         = disp_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        sample_c       = 1'b0;
`ifdef DICE_SETTLE_ANIM_EN
        step_d     = step_q;
        interval_c = TICK_W'(ANIM_BASE * (32'(step_q) + 32'd2));
`else
        pend_d = pend_q;
`endif

        // Sample tick generation; the face is sampled before any transition
        case (state_q)
            ROLLING: begin
                sample_c = (tick_q == TICK_WRAP);
`ifndef DICE_SETTLE_ANIM_EN
                sample_c = sample_c || pend_q;
`endif
                tick_d = (tick_q == TICK_WRAP) ? '0 : tick_q + TICK_W'(1);
            end
`ifdef DICE_SETTLE_ANIM_EN
            SETTLING: begin
                if (step_q == STEP_W'(SETTLE_STEPS)) begin
                    sample_c = 1'b1;
                    tick_d   = '0;
                end else if (tick_q == interval_c - TICK_W'(1)) begin
                    sample_c = 1'b1;
                    tick_d   = '0;
                    step_d   = step_q + STEP_W'(1);
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
`endif
            default: ;
        endcase

        if (sample_c && face_valid(dice_value)) begin
            disp_d = dice_value;
        end

        case (state_q)
            IDLE, SHOW: begin
                if (press_c) begin
                    state_d = ROLLING;
                    tick_d  = TICK_WRAP;
                end
            end
            ROLLING: begin
`ifdef DICE_SETTLE_ANIM_EN
                if (release_c) begin
                    state_d = SETTLING;
                    tick_d  = '0;
                    step_d  = '0;
                end
`else
                // Without settling, a release waits here until a legal face is held
                if (press_c) begin
                    pend_d = 1'b0;
                end else if (release_c || pend_q) begin
                    if (face_valid(disp_d)) begin
                        state_d        = SHOW;
                        result_d       = disp_d;
                        result_valid_d = 1'b1;
                        pend_d         = 1'b0;
                    end else begin
                        pend_d = 1'b1;
                    end
                end
`endif
            end
`ifdef DICE_SETTLE_ANIM_EN
            SETTLING: begin
                if (press_c) begin
                    state_d = ROLLING;
                    tick_d  = TICK_WRAP;
                    step_d  = '0;
                end else if (sample_c && (step_q >= STEP_W'(SETTLE_STEPS - 1))
                             && face_valid(disp_d)) begin
                    state_d        = SHOW;
                    result_d       = disp_d;
                    result_valid_d = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        busy_d     = (state_d == ROLLING) || (state_d == SETTLING);
        is_three_d = (state_d == SHOW) && (result_d == FACE_W'(3));
        case (state_d)
            IDLE:    pips_d = PIPS_OFF;
            SHOW:    pips_d = face_to_pips(result_d);
            default: pips_d = face_to_pips(disp_d);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            tick_q         <= '0;
            disp_q         <= '0;
            result_q       <= '0;
            pips_q         <= PIPS_OFF;
            result_valid_q <= 1'b0;
            is_three_q     <= 1'b0;
            busy_q         <= 1'b0;
`ifdef DICE_SETTLE_ANIM_EN
            step_q         <= '0;
`else
            pend_q         <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            tick_q         <= tick_d;
            disp_q         <= disp_d;
            result_q       <= result_d;
            pips_q         <= pips_d;
            result_valid_q <= result_valid_d;
            is_three_q     <= is_three_d;
            busy_q         <= busy_d;
`ifdef DICE_SETTLE_ANIM_EN
            step_q         <= step_d;
`else
            pend_q         <= pend_d;
`endif
        end
    end

    assign pips         = pips_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign is_three     = is_three_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Self-checking bench for dice_roll_ctrl: directed scenarios plus randomized
// rolls compared against a roll-level reference model.
module tb_dice_roll_ctrl;

    localparam int unsigned DEB   = 4;
    localparam int unsigned ANIM  = 2;
    localparam int unsigned STEPS = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] dice_value;
    logic       btn;
    logic [6:0] pips;
    logic [2:0] result;
    logic       result_valid;
    logic       is_three;
    logic       busy;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    // Model state: face on the display register and last latched result
    logic [2:0] disp_m   = 3'd0;
    logic [2:0] prev_res = 3'd0;

    always #5 clk = ~clk;

    dice_roll_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .ANIM_BASE      (ANIM),
        .SETTLE_STEPS   (STEPS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .dice_value   (dice_value),
        .btn          (btn),
        .pips         (pips),
        .result       (result),
        .result_valid (result_valid),
        .is_three     (is_three),
        .busy         (busy)
    );

    function automatic logic [6:0] pips_of(input logic [2:0] f);
        case (f)
            3'd1:    return 7'b0001000;
            3'd2:    return 7'b1000001;
            3'd3:    return 7'b1001001;
            3'd4:    return 7'b1100011;
            3'd5:    return 7'b1101011;
            3'd6:    return 7'b1110111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic bit legal(input logic [2:0] f);
        return (f >= 3'd1) && (f <= 3'd6);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_phase(input logic [2:0] face, input int hold);
        dice_value = face;
        btn        = 1'b1;
        cyc(5);
        check_eq("busy_before_event", 32'(busy), 32'd0);
        cyc(1);
        check_eq("busy_rise", 32'(busy), 32'd1);
        cyc(hold - 6);
        check_eq("busy_hold", 32'(busy), 32'd1);
        check_eq("result_hold", 32'(result), 32'(prev_res));
        check_eq("no_pulse_rolling", 32'(result_valid), 32'd0);
    endtask

    task automatic release_phase(input logic [2:0] face, input logic [2:0] late);
        logic [2:0] exp;
        int         pulses;
        int         at;
        int         exp_at;
        pulses = 0;
        at     = -1;
`ifdef DICE_SETTLE_ANIM_EN
        exp    = legal(face) ? face : late;
        exp_at = 5;
        for (int k = 0; k < int'(STEPS); k++) exp_at += int'(ANIM) * (k + 2);
`else
        exp    = legal(face) ? face : ((disp_m != 3'd0) ? disp_m : late);
        exp_at = (legal(face) || disp_m != 3'd0) ? 5 : 11;
`endif
        btn = 1'b0;
        for (int i = 0; i < 60; i++) begin
            cyc(1);
            if (result_valid) begin
                pulses++;
                if (at < 0) at = i;
            end
            if (i == 10 && !legal(face)) dice_value = late;
        end
        check_eq("pulse_count", 32'(pulses), 32'd1);
        check_eq("pulse_time", 32'(at), 32'(exp_at));
        check_eq("result", 32'(result), 32'(exp));
        check_eq("pips_show", 32'(pips), 32'(pips_of(exp)));
        check_eq("is_three", 32'(is_three), 32'(exp == 3'd3));
        check_eq("busy_show", 32'(busy), 32'd0);
        disp_m   = exp;
        prev_res = exp;
    endtask

    task automatic glitch(input int len);
        int bad;
        bad = 0;
        btn = 1'b1;
        cyc(len);
        btn = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (busy || result_valid) bad++;
        end
        check_eq("glitch_ignored", 32'(bad), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        btn        = 1'b0;
        dice_value = 3'd0;
        #20 rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cyc(1);
            check_eq("reset_idle", 32'({pips, result, result_valid, is_three, busy}), 32'd0);
        end

        // Basic roll of a 3
        press_phase(3'd3, 20);
        release_phase(3'd3, 3'd3);

        for (int g = 1; g <= 3; g++) glitch(g);

        // Invalid face throughout the roll, legal face arrives after release
        press_phase(3'd7, 20);
        release_phase(3'd7, 3'd5);

`ifdef DICE_SETTLE_ANIM_EN
        begin
            int pulses;
            press_phase(3'd2, 15);
            btn = 1'b0;
            cyc(10);
            check_eq("settling_busy", 32'(busy), 32'd1);
            pulses     = 0;
            btn        = 1'b1;
            dice_value = 3'd4;
            for (int i = 0; i < 20; i++) begin
                cyc(1);
                if (result_valid) pulses++;
            end
            check_eq("repress_no_pulse", 32'(pulses), 32'd0);
            check_eq("repress_busy", 32'(busy), 32'd1);
            release_phase(3'd4, 3'd4);
        end
`endif

        // Reset in the middle of a roll
        begin
            int pulses;
            dice_value = 3'd1;
            btn        = 1'b1;
            cyc(10);
            check_eq("rolling_before_rst", 32'(busy), 32'd1);
            rst = 1'b1;
            btn = 1'b0;
            cyc(1);
            check_eq("rst_outputs", 32'({pips, result, result_valid, is_three, busy}), 32'd0);
            rst    = 1'b0;
            pulses = 0;
            for (int i = 0; i < 20; i++) begin
                cyc(1);
                if (result_valid || busy) pulses++;
            end
            check_eq("rst_no_pulse", 32'(pulses), 32'd0);
            disp_m   = 3'd0;
            prev_res = 3'd0;
        end

        press_phase(3'd6, 20);
        release_phase(3'd6, 3'd6);

        for (int r = 0; r < 12; r++) begin
            logic [2:0] face;
            logic [2:0] late;
            face = 3'($urandom_range(0, 7));
            late = 3'($urandom_range(1, 6));
            press_phase(face, int'($urandom_range(10, 30)));
            release_phase(face, late);
            if ($urandom_range(0, 1) == 1) glitch(int'($urandom_range(1, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
